// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, instruction
// field layout and register-address width.
package alu_issue_pkg;

  localparam int INSTR_W    = 16;
  localparam int OP_W       = 3;
  localparam int REG_ADDR_W = 3;

  // Opcode encodings understood by the ALU. Codes 5..7 are not listed; the
  // issue stage passes them through untouched and the ALU answers with 0.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } opcode_e;

  // Instruction layout, MSB first: [15:13] opcode, [12:10] rd,
  // [9:7] rs1, [6:4] rs2, [3:0] don't care.
  typedef struct packed {
    logic [OP_W-1:0]       opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [3:0]            pad;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    return instr_t'(raw);
  endfunction

  // Build a raw instruction word from its fields (pad bits zero).
  function automatic logic [INSTR_W-1:0] encode_instr(
    input logic [OP_W-1:0]       opcode,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2
  );
    return {opcode, rd, rs1, rs2, 4'b0000};
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Eight-entry register file: two combinational read ports, one retire write
// port and one host write port. r0 is hard-wired to zero. When both write
// ports target the same register on one edge, the retire write wins.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_a,
  output logic [DATAWIDTH-1:0]  o_rd_data_a,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_b,
  output logic [DATAWIDTH-1:0]  o_rd_data_b,
  input  logic                  i_ret_we,
  input  logic [REG_ADDR_W-1:0] i_ret_addr,
  input  logic [DATAWIDTH-1:0]  i_ret_data,
  input  logic                  i_host_we,
  input  logic [REG_ADDR_W-1:0] i_host_addr,
  input  logic [DATAWIDTH-1:0]  i_host_data
);

  logic [DATAWIDTH-1:0] r_regs [NREGS];

  // Storage update: entry 0 is never written, retire has priority over host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (i_ret_we && (i_ret_addr == REG_ADDR_W'(i))) begin
          r_regs[i] <= i_ret_data;
        end else if (i_host_we && (i_host_addr == REG_ADDR_W'(i))) begin
          r_regs[i] <= i_host_data;
        end
      end
    end
  end

  // Read ports: address 0 always returns zero.
  always_comb begin
    o_rd_data_a = '0;
    o_rd_data_b = '0;
    if (i_rd_addr_a != '0) o_rd_data_a = r_regs[i_rd_addr_a];
    if (i_rd_addr_b != '0) o_rd_data_b = r_regs[i_rd_addr_b];
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one instruction at a time, reads its operands from
// the register file (with bypassing of same-edge writes), holds them for the
// downstream ALU, and writes the ALU result back when the ALU side retires it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream (in_valid/in_ready) may hold in_valid and the instruction
// until accepted; downstream (out_valid/out_ready) sees out_valid and the
// operands held stable until out_ready is high. in_ready depends only on the
// output stage (!out_valid || out_ready), never on in_valid.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_W-1:0]       opcode,
  output logic [DATAWIDTH-1:0]  data1,
  output logic [DATAWIDTH-1:0]  data2,
  input  logic [DATAWIDTH-1:0]  alu_result,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0]  wr_data,
  output logic [15:0]           retired_cnt
);

  // Output stage registers.
  logic                  r_out_valid;
  logic [OP_W-1:0]       r_opcode;
  logic [DATAWIDTH-1:0]  r_data1;
  logic [DATAWIDTH-1:0]  r_data2;
  logic [REG_ADDR_W-1:0] r_held_rd;
  logic [15:0]           r_retired_cnt;

  // Decode and handshake wires.
  instr_t                w_instr;
  logic [3:0]            w_unused_pad;
  logic                  w_accept;
  logic                  w_retire;
  logic [DATAWIDTH-1:0]  w_rf_rd_a;
  logic [DATAWIDTH-1:0]  w_rf_rd_b;
  logic [DATAWIDTH-1:0]  w_op_a;
  logic [DATAWIDTH-1:0]  w_op_b;

  assign w_instr      = decode_instr(in_instr);
  assign w_unused_pad = w_instr.pad;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = r_out_valid && out_ready;

  assign out_valid   = r_out_valid;
  assign opcode      = r_opcode;
  assign data1       = r_data1;
  assign data2       = r_data2;
  assign retired_cnt = r_retired_cnt;

  alu_issue_regfile #(
    .DATAWIDTH (DATAWIDTH),
    .NREGS     (NREGS)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_addr_a (w_instr.rs1),
    .o_rd_data_a (w_rf_rd_a),
    .i_rd_addr_b (w_instr.rs2),
    .o_rd_data_b (w_rf_rd_b),
    .i_ret_we    (w_retire),
    .i_ret_addr  (r_held_rd),
    .i_ret_data  (alu_result),
    .i_host_we   (wr_en),
    .i_host_addr (wr_addr),
    .i_host_data (wr_data)
  );

  // Operand bypass: a retiring result to the same nonzero register beats a
  // same-edge host write, which in turn beats the stored register value.
  // Register 0 never bypasses, so it always reads zero.
  always_comb begin
    w_op_a = w_rf_rd_a;
    w_op_b = w_rf_rd_b;
    if (w_instr.rs1 != '0) begin
      if (w_retire && (r_held_rd == w_instr.rs1)) begin
        w_op_a = alu_result;
      end else if (wr_en && (wr_addr == w_instr.rs1)) begin
        w_op_a = wr_data;
      end
    end
    if (w_instr.rs2 != '0) begin
      if (w_retire && (r_held_rd == w_instr.rs2)) begin
        w_op_b = alu_result;
      end else if (wr_en && (wr_addr == w_instr.rs2)) begin
        w_op_b = wr_data;
      end
    end
  end

  // Output stage: load on accept, drop valid on retire without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_held_rd   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_instr.opcode;
      r_data1     <= w_op_a;
      r_data2     <= w_op_b;
      r_held_rd   <= w_instr.rd;
    end else if (w_retire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Retire counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue. Inputs change and outputs are checked on
// the falling clock edge; the DUT acts on the rising edge.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [15:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    opcode;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [DW-1:0] alu_result;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   retired_cnt;

  int n_cmp;
  int n_mis;
  int exp_cnt;

  alu_issue #(.DATAWIDTH(DW), .NREGS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .data1       (data1),
    .data2       (data2),
    .alu_result  (alu_result),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .retired_cnt (retired_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driving the combinational result input.
  always_comb begin
    alu_result = '0;
    case (opcode)
      3'b000:  alu_result = data1 + data2;
      3'b001:  alu_result = data1 - data2;
      3'b010:  alu_result = data1 & data2;
      3'b011:  alu_result = data1 | data2;
      3'b100:  alu_result = data1 ^ data2;
      default: alu_result = '0;
    endcase
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic host_write(input logic [2:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issue ADD r0,rs,r0 so rs appears on data1; the retire increments the count.
  task automatic read_reg(input logic [2:0] rs, input logic [DW-1:0] exp, input string name);
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd0, rs, 3'd0); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (data1 !== exp) begin
      n_mis++;
      $display("FAIL %s: r%0d got %h expected %h", name, rs, data1, exp);
    end
    @(negedge clk);
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, opcode, data1, data2, retired_cnt} !== {1'b0, 1'b1, 3'd0, 64'd0, 16'd0}) begin
      n_mis++;
      $display("FAIL reset_state: ov=%b ir=%b op=%h d1=%h d2=%h cnt=%h expected 0 1 0 0 0 0",
               out_valid, in_ready, opcode, data1, data2, retired_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd3, 3'd1, 3'd2); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, opcode, data1, data2} !== {1'b1, 3'b000, 32'd5, 32'd3}) begin
      n_mis++;
      $display("FAIL add_issue: ov=%b op=%h d1=%h d2=%h expected 1 0 5 3", out_valid, opcode, data1, data2);
    end
    @(negedge clk);
    exp_cnt++;
    n_cmp++;
    if ({out_valid, retired_cnt} !== {1'b0, 16'd1}) begin
      n_mis++;
      $display("FAIL add_retire: ov=%b cnt=%h expected 0 0001", out_valid, retired_cnt);
    end
    read_reg(3'd3, 32'd8, "add_r3");
  endtask

  task automatic test_back_to_back();
    host_write(3'd5, 32'hDEAD);
    in_valid = 1'b1; in_instr = encode_instr(OP_SUB, 3'd4, 3'd3, 3'd1); out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({opcode, data1, data2} !== {3'b001, 32'd8, 32'd5}) begin
      n_mis++;
      $display("FAIL b2b_sub: op=%h d1=%h d2=%h expected 1 8 5", opcode, data1, data2);
    end
    in_instr = encode_instr(OP_XOR, 3'd5, 3'd4, 3'd4);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, opcode, data1, data2} !== {1'b1, 3'b100, 32'd3, 32'd3}) begin
      n_mis++;
      $display("FAIL b2b_xor_bypass: ov=%b op=%h d1=%h d2=%h expected 1 4 3 3", out_valid, opcode, data1, data2);
    end
    @(negedge clk);
    exp_cnt += 2;
    n_cmp++;
    if (retired_cnt !== 16'(exp_cnt)) begin
      n_mis++;
      $display("FAIL b2b_count: got %h expected %h", retired_cnt, 16'(exp_cnt));
    end
    read_reg(3'd4, 32'd3, "b2b_r4");
    read_reg(3'd5, 32'd0, "b2b_r5");
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_instr = encode_instr(OP_OR, 3'd7, 3'd1, 3'd2); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({in_ready, out_valid, opcode, data1, data2, retired_cnt} !==
          {1'b0, 1'b1, 3'b011, 32'd5, 32'd3, 16'(exp_cnt)}) begin
        n_mis++;
        $display("FAIL stall_hold[%0d]: ir=%b ov=%b op=%h d1=%h d2=%h cnt=%h expected 0 1 3 5 3 %h",
                 i, in_ready, out_valid, opcode, data1, data2, retired_cnt, 16'(exp_cnt));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    n_cmp++;
    if ({out_valid, retired_cnt} !== {1'b0, 16'(exp_cnt)}) begin
      n_mis++;
      $display("FAIL stall_release: ov=%b cnt=%h expected 0 %h", out_valid, retired_cnt, 16'(exp_cnt));
    end
    read_reg(3'd7, 32'd7, "stall_r7");
  endtask

  task automatic test_opcode_passthru();
    in_valid = 1'b1; in_instr = encode_instr(3'd6, 3'd4, 3'd1, 3'd2); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({opcode, data1, data2} !== {3'd6, 32'd5, 32'd3}) begin
      n_mis++;
      $display("FAIL op6_issue: op=%h d1=%h d2=%h expected 6 5 3", opcode, data1, data2);
    end
    @(negedge clk);
    exp_cnt++;
    read_reg(3'd4, 32'd0, "op6_r4");
  endtask

  task automatic test_host_bypass();
    // Host write and accept reading the same register on one edge.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h77;
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd3, 3'd2, 3'd2); out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({data1, data2} !== {32'h77, 32'h77}) begin
      n_mis++;
      $display("FAIL host_bypass: d1=%h d2=%h expected 77 77", data1, data2);
    end
    // Retire to r3, host write to r3 and accept reading r3 on one edge.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h999;
    in_instr = encode_instr(OP_ADD, 3'd0, 3'd3, 3'd0); out_ready = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; in_valid = 1'b0;
    exp_cnt++;
    n_cmp++;
    if (data1 !== 32'hEE) begin
      n_mis++;
      $display("FAIL retire_bypass_priority: d1=%h expected ee", data1);
    end
    @(negedge clk);
    exp_cnt++;
    read_reg(3'd3, 32'hEE, "prio_r3");
    read_reg(3'd2, 32'h77, "prio_r2");
  endtask

  task automatic test_collision();
    host_write(3'd1, 32'h1234);
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd6, 3'd1, 3'd0); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hAAAA_AAAA; out_ready = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    exp_cnt++;
    in_valid = 1'b1; in_instr = encode_instr(OP_AND, 3'd7, 3'd1, 3'd1); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h55; out_ready = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    exp_cnt++;
    read_reg(3'd6, 32'h1234, "collide_r6");
    read_reg(3'd7, 32'h1234, "collide_r7");
    read_reg(3'd2, 32'h55, "collide_r2");
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd0, 3'd1, 3'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    exp_cnt++;
    read_reg(3'd0, 32'd0, "r0_zero");
    n_cmp++;
    if (retired_cnt !== 16'(exp_cnt)) begin
      n_mis++;
      $display("FAIL collide_count: got %h expected %h", retired_cnt, 16'(exp_cnt));
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd5, 3'd1, 3'd1); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL midreset_pre: ov=%b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, opcode, data1, data2, retired_cnt} !== {1'b0, 1'b1, 3'd0, 64'd0, 16'd0}) begin
      n_mis++;
      $display("FAIL midreset_async: ov=%b ir=%b op=%h d1=%h d2=%h cnt=%h expected 0 1 0 0 0 0",
               out_valid, in_ready, opcode, data1, data2, retired_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; exp_cnt = 0;
    read_reg(3'd1, 32'd0, "midreset_r1");
    read_reg(3'd5, 32'd0, "midreset_r5");
    read_reg(3'd6, 32'd0, "midreset_r6");
    n_cmp++;
    if (retired_cnt !== 16'(exp_cnt)) begin
      n_mis++;
      $display("FAIL midreset_count: got %h expected %h", retired_cnt, 16'(exp_cnt));
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_instr = encode_instr(OP_ADD, 3'd0, 3'd0, 3'd0); out_ready = 1'b1;
    // First edge only accepts; each later edge retires one and accepts one.
    repeat (65536) @(negedge clk);
    n_cmp++;
    if (retired_cnt !== 16'hFFFF) begin
      n_mis++;
      $display("FAIL wrap_ffff: got %h expected ffff", retired_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, retired_cnt} !== {1'b0, 16'h0000}) begin
      n_mis++;
      $display("FAIL wrap_zero: ov=%b cnt=%h expected 0 0000", out_valid, retired_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_opcode_passthru();
    test_host_bypass();
    test_collision();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter NREGS, default 8, register-file depth (fixed to 8 by 3-bit fields).
REQ-003 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid input 1: instruction present.
REQ-006 SHALL have port in_instr input 16: instruction [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
REQ-007 SHALL have port in_ready output 1: instruction accepted when in_valid&&in_ready.
REQ-008 SHALL have port out_valid output 1: opcode/data1/data2 valid toward ALU.
REQ-009 SHALL have port out_ready input 1: downstream accepts; retire = out_valid&&out_ready.
REQ-010 SHALL have ports opcode output 3, data1 output DATAWIDTH, data2 output DATAWIDTH: registered ALU operands.
REQ-011 SHALL have port alu_result input DATAWIDTH: combinational ALU result for the held operands.
REQ-012 SHALL have ports wr_en input 1, wr_addr input 3, wr_data input DATAWIDTH: host register-file write port.
REQ-013 SHALL have port retired_cnt output 16: count of retired instructions.

Function
REQ-014 SHALL hold an 8-entry DATAWIDTH register file; r0 reads as zero, writes to r0 ignored.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (one-entry output stage, no combinational path from in_valid).
REQ-016 On accept, SHALL register opcode=in_instr[15:13], data1=R[rs1], data2=R[rs2], held_rd=rd, and set out_valid next cycle (latency 1).
REQ-017 On retire, SHALL write alu_result into R[held_rd] at that clock edge; out_valid clears unless a new accept occurs same edge.
REQ-018 Simultaneous retire and accept: operand read of rsN equal to held_rd (nonzero) SHALL take alu_result (bypass), not the stale register.
REQ-019 Host write and retire to same address same edge: retire SHALL win; host write to different address both take effect.
REQ-020 Host write and accept same edge with rsN == wr_addr: accepted operand SHALL use wr_data (bypass), unless REQ-018 applies, which has priority.
REQ-021 While out_valid && !out_ready, opcode/data1/data2 SHALL remain stable.
REQ-022 Opcodes 5-7 SHALL be issued unchanged (ALU yields 0, written to rd).
REQ-023 retired_cnt SHALL increment by 1 per retire, wrapping 0xFFFF -> 0x0000.

Reset
REQ-024 rst_n low SHALL immediately clear out_valid, opcode, data1, data2, held_rd, retired_cnt and all registers to 0.
REQ-025 Reset mid-operation SHALL discard the held instruction without writeback; in_ready = 1 during and after reset.

Structure
REQ-026 Opcode encodings (ADD 000, SUB 001, AND 010, OR 011, XOR 100) and instruction field positions SHALL live in a shared package used by alu and alu_issue.
REQ-027 Register file SHALL be one sub-module, regfile (2 read ports, 1 retire write port, 1 host write port, r0 zero, reset clear); bypass muxing stays in alu_issue.

Verification
REQ-028 Host writes r1=5, r2=3; issue ADD r3,r1,r2 with out_ready=1 -> cycle+1 opcode=000,data1=5,data2=3; after retire r3=8, retired_cnt=1.
REQ-029 Back-to-back SUB r4,r3,r1 then XOR r5,r4,r4 accepted on consecutive cycles -> second instruction data1=data2=3 via bypass; r5=0.
REQ-030 out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, operands stable, no writeback; release -> single retire.
REQ-031 Host write r6=0xAAAA_AAAA same edge as retire to r6 of 0x1234 -> r6=0x1234; issue targeting r0 -> r0 reads 0.
REQ-032 Assert rst_n low while out_valid=1 -> out_valid=0 asynchronously, all registers 0, retired_cnt=0, no writeback.
REQ-033 Force 65536 retires -> retired_cnt returns to 0x0000.
